// File: rtl/add_seq_ctrl.sv
// Nibble-serial W-bit add/subtract controller. One 4-bit carry-lookahead
// adder (sum4) is reused for every nibble, starting with the LSB nibble.

module sum4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c3_o,
    output logic       c4_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o  = p ^ c[3:0];
    assign c3_o = c[3];
    assign c4_o = c[4];
endmodule

module add_seq_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           op_sub,
    input  logic [4*N-1:0] a,
    input  logic [4*N-1:0] b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [4*N-1:0] s,
    output logic           c_out,
    output logic           ovf,
    output logic           zero
);
    localparam int W  = 4 * N;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    s_q;
    logic [W-1:0]    s_d;
    logic            c_out_q;
    logic            ovf_q;
    logic            zero_q;

    logic [IW+1:0]   lo;
    logic [3:0]      nib_sum;
    logic            nib_c3;
    logic            nib_c4;

    assign lo = {idx_q, 2'b00};

    sum4 u_sum4 (
        .a_i  (a_q[lo +: 4]),
        .b_i  (b_q[lo +: 4]),
        .c_i  (carry_q),
        .s_o  (nib_sum),
        .c3_o (nib_c3),
        .c4_o (nib_c4)
    );

    // Result with the current nibble merged in; the zero flag is taken from
    // this so it reflects the final word on the last RUN cycle.
    always_comb begin
        s_d          = s_q;
        s_d[lo +: 4] = nib_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= nib_c4;
                    if (idx_q == LAST) begin
                        c_out_q <= nib_c4;
                        ovf_q   <= nib_c3 ^ nib_c4;
                        zero_q  <= (s_d == '0);
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (N=4): hand-computed results, timing,
// start-while-busy, mid-run reset and back-to-back operation.

module tb_add_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    add_seq_ctrl #(.N(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .s      (s),
        .c_out  (c_out),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sub, input logic [15:0] es, input logic ec,
                          input logic eo, input logic ez);
        int n;
        int busy_cnt;
        @(negedge clk);
        check({tag, ".ready"}, ready, 1'b1);
        a = av; b = bv; op_sub = sub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op_sub = ~sub;
        n = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            n++;
            @(negedge clk);
        end
        check({tag, ".done"},    done, 1'b1);
        check({tag, ".latency"}, n, 4);
        check({tag, ".busy"},    busy_cnt, 4);
        check({tag, ".s"},       s, es);
        check({tag, ".c_out"},   c_out, ec);
        check({tag, ".ovf"},     ovf, eo);
        check({tag, ".zero"},    zero, ez);
        @(negedge clk);
        check({tag, ".pulse"},   done, 1'b0);
        check({tag, ".hold"},    s, es);
    endtask

    initial begin
        int n;
        int dones;
        int last_done;
        logic [15:0] bb_a  [3] = '{16'h0101, 16'h0010, 16'h8000};
        logic [15:0] bb_b  [3] = '{16'h0202, 16'h0001, 16'h8000};
        logic        bb_sb [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] bb_s  [3] = '{16'h0303, 16'h000F, 16'h0000};

        reset = 1'b1; start = 1'b1; op_sub = 1'b0; a = 16'hFFFF; b = 16'h0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", ready, 1'b1);
        check("rst.busy",  busy,  1'b0);
        check("rst.done",  done,  1'b0);
        check("rst.s",     s,     16'h0);
        check("rst.flags", {c_out, ovf, zero}, 3'b000);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst.idle", ready, 1'b1);

        run_op("add1",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("addc",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("addo",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("subn",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("subo",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // start held with new operands through RUN and DONE
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hFFFF; b = 16'hFFFF;
        dones = 0; n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            if (done) dones++;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ign.ready", ready, 1'b1);
        check("ign.dones", dones, 1);
        check("ign.cycles", n, 5);
        check("ign.s",     s, 16'h2222);
        @(negedge clk);
        check("ign.idle",  ready, 1'b1);
        check("ign.hold",  s, 16'h2222);

        // reset two edges into a run
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort.ready", ready, 1'b1);
        check("abort.busy",  busy, 1'b0);
        check("abort.s",     s, 16'h0);
        dones = 0;
        repeat (8) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort.nodone", dones, 0);
        run_op("post", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

        // back-to-back with start held high
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; op_sub = bb_sb[0]; start = 1'b1;
        last_done = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!done && n < 20) begin
                n++;
                @(negedge clk);
            end
            check($sformatf("b2b%0d.done", k), done, 1'b1);
            check($sformatf("b2b%0d.s", k), s, bb_s[k]);
            if (k > 0) check($sformatf("b2b%0d.period", k), cyc - last_done, 6);
            last_done = cyc;
            if (k < 2) begin
                a = bb_a[k+1]; b = bb_b[k+1]; op_sub = bb_sb[k+1];
            end
        end
        check("b2b2.flags", {c_out, ovf, zero}, 3'b111);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b.idle", ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001: Parameter N, default 4, number of 4-bit nibbles per operand; operand width W = 4*N; N SHALL be >= 2.
REQ-002: clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: start  input  1  request; accepted only when ready=1.
REQ-005: op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006: a  input  W  operand A; sampled with start.
REQ-007: b  input  W  operand B; sampled with start.
REQ-008: ready  output  1  high when idle and able to accept start.
REQ-009: busy  output  1  high while nibbles are being summed.
REQ-010: done  output  1  one-cycle pulse when the result becomes valid.
REQ-011: s  output  W  result register.
REQ-012: c_out  output  1  raw carry out of the most-significant nibble (for subtract: 1 = no borrow).
REQ-013: ovf  output  1  two's-complement overflow of the full W-bit operation.
REQ-014: zero  output  1  high when s == 0.

Function
REQ-015: The block SHALL instantiate exactly one existing 4-bit carry-lookahead adder (sum4) and time-share it across all N nibbles, LSB nibble first.
REQ-016: FSM states SHALL be IDLE, RUN, DONE; ready = (state==IDLE), busy = (state==RUN), done = (state==DONE).
REQ-017: IDLE with start=1: latch a into a_reg; latch b (bitwise-inverted if op_sub=1) into b_reg; carry_reg <= op_sub; idx <= 0; go to RUN.
REQ-018: IDLE with start=0: hold all registers and outputs unchanged.
REQ-019: RUN, each cycle: adder inputs = nibble idx of a_reg and b_reg plus carry_reg; s[4*idx+3:4*idx] <= adder sum; carry_reg <= adder c_out; idx <= idx+1.
REQ-020: RUN with idx==N-1: additionally c_out <= adder C[4], ovf <= adder C[3] XOR adder C[4], zero <= (final W-bit s == 0); go to DONE.
REQ-021: DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-022: Latency: start accepted at edge k -> done high during the cycle following edge k+N; next start accepted no earlier than edge k+N+2.
REQ-023: start while busy or done SHALL be ignored (no re-latch, no effect on operands, idx or outputs).
REQ-024: s, c_out, ovf, zero SHALL be stable and valid from the done cycle until the next accepted start; upper nibbles of s MAY change during RUN.
REQ-025: idx SHALL be ceil(log2(N)) bits wide and SHALL never exceed N-1.
REQ-026: Changes on a, b, op_sub after acceptance SHALL not affect the running operation.

Reset
REQ-027: reset=1 at a rising edge SHALL force state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, s=0, c_out=0, ovf=0, zero=0; hence ready=1, busy=0, done=0.
REQ-028: reset SHALL take priority over start and over any RUN/DONE activity; an aborted operation SHALL produce no done pulse.
REQ-029: start asserted in the same cycle as reset SHALL be ignored.

Verification (N=4)
REQ-030: add 0x1234 + 0x4321, start at edge 0 -> done high after edge 4, s=0x5555, c_out=0, ovf=0, zero=0; busy high for exactly 4 cycles.
REQ-031: add 0xFFFF + 0x0001 -> s=0x0000, c_out=1, ovf=0, zero=1; add 0x7FFF + 0x0001 -> s=0x8000, c_out=0, ovf=1, zero=0.
REQ-032: sub 0x0005 - 0x0007 -> s=0xFFFE, c_out=0, ovf=0; sub 0x8000 - 0x0001 -> s=0x7FFF, c_out=1, ovf=1.
REQ-033: start 0x1111+0x1111, then start=1 with a=0xFFFF, b=0xFFFF on every RUN/DONE cycle -> single done pulse, s=0x2222; new operation accepted only once ready=1.
REQ-034: reset asserted at edge 2 of a run -> next cycle ready=1, busy=0, s=0, no done pulse; following add 0x0003+0x0004 -> s=0x0007.
REQ-035: back-to-back: start held high continuously -> operations accepted every N+2 = 6 cycles, one done pulse per operation, results correct each time.
